// File: rtl/vram_dma.sv
// rtl/vram_dma.sv - VRAM general/HBlank DMA engine with MMIO register file
module vram_dma #(
  parameter int          BLOCK_BYTES = 16,
  parameter int          LEN_BITS    = 7,
  parameter logic [15:0] DEST_BASE   = 16'h8000,
  parameter int          DEST_BITS   = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mmio_sel,
  input  logic        mmio_wr,
  input  logic [7:0]  mmio_din,
  output logic [7:0]  mmio_dout,
  input  logic        hblank_start,
  output logic        dma_rd,
  output logic        dma_wr,
  output logic [15:0] dma_a,
  input  logic [7:0]  dma_din,
  output logic [7:0]  dma_dout,
  output logic        cpu_stall,
  output logic        dma_occupy_extbus,
  output logic        dma_occupy_vidbus
);

  localparam int                  OFF_BITS = $clog2(BLOCK_BYTES);
  localparam logic [OFF_BITS-1:0] OFF_ONE  = 1;
  localparam logic [OFF_BITS-1:0] OFF_LAST = OFF_BITS'(BLOCK_BYTES - 1);
  localparam logic [LEN_BITS:0]   REM_ONE  = 1;
  localparam logic [DEST_BITS-1:0] DST_ONE = 1;
  localparam logic [15:0]         DST_MASK = 16'((32'd1 << DEST_BITS) - 32'd1) & 16'hFFF0;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_RD_ADDR, S_RD_WAIT, S_WR, S_WR_WAIT
  } state_t;

  state_t               state, next_state;
  logic [15:0]          src_reg, dst_reg;
  logic [15:0]          src_cnt;
  logic [DEST_BITS-1:0] dst_off;
  logic [OFF_BITS-1:0]  byte_cnt;
  logic [LEN_BITS:0]    remaining;
  logic                 hdma, cancelled;
  logic                 pend_restart, pend_cancel;
  logic [LEN_BITS-1:0]  pend_len;

  logic                 ctrl_wr, byte_state, last_byte, wr_hdma_ctrl;
  logic                 eff_restart, eff_cancel;
  logic [LEN_BITS-1:0]  eff_len, ld_len;
  logic                 ld_hdma, load, cancel;
  logic [LEN_BITS:0]    rem_m1;
  logic [7:0]           ctrl_rb;
  logic [15:0]          dest_addr;

  assign ctrl_wr      = mmio_wr && (mmio_sel == 3'd4);
  assign byte_state   = (state == S_RD_ADDR) || (state == S_RD_WAIT) ||
                        (state == S_WR) || (state == S_WR_WAIT);
  assign last_byte    = (state == S_WR_WAIT) && (byte_cnt == OFF_LAST);
  // CTRL writes during an HDMA block are deferred; a write in the final cycle still counts.
  assign wr_hdma_ctrl = ctrl_wr && hdma && byte_state;
  assign eff_restart  = wr_hdma_ctrl ? mmio_din[7]  : pend_restart;
  assign eff_cancel   = wr_hdma_ctrl ? ~mmio_din[7] : pend_cancel;
  assign eff_len      = wr_hdma_ctrl ? mmio_din[LEN_BITS-1:0] : pend_len;
  assign ld_len       = (state == S_WR_WAIT) ? eff_len : mmio_din[LEN_BITS-1:0];
  assign ld_hdma      = (state == S_WR_WAIT) || mmio_din[7];
  assign dest_addr    = DEST_BASE | 16'(dst_off);

  assign rem_m1    = remaining - REM_ONE;
  assign ctrl_rb   = (state != S_IDLE) ? {1'b0, 7'(rem_m1)} :
                     cancelled         ? {1'b1, 7'(rem_m1)} : 8'hFF;
  assign mmio_dout = (mmio_sel == 3'd4) ? ctrl_rb : 8'hFF;

  assign cpu_stall         = byte_state;
  assign dma_occupy_vidbus = byte_state;
  assign dma_occupy_extbus = byte_state && (src_cnt[15:13] != 3'b100);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode plus load/cancel strobes for the datapath
  always_comb begin
    next_state = state;
    load       = 1'b0;
    cancel     = 1'b0;
    case (state)
      S_IDLE: if (ctrl_wr) begin
        load       = 1'b1;
        next_state = mmio_din[7] ? S_ARMED : S_RD_ADDR;
      end
      S_ARMED: begin
        if (ctrl_wr) begin
          if (mmio_din[7]) load = 1'b1;
          else begin
            cancel     = 1'b1;
            next_state = S_IDLE;
          end
        end else if (hblank_start) next_state = S_RD_ADDR;
      end
      S_RD_ADDR: next_state = S_RD_WAIT;
      S_RD_WAIT: next_state = S_WR;
      S_WR:      next_state = S_WR_WAIT;
      S_WR_WAIT: begin
        if (!last_byte)                 next_state = S_RD_ADDR;
        else if (hdma && eff_restart) begin
          load       = 1'b1;
          next_state = S_ARMED;
        end else if (hdma && eff_cancel) begin
          cancel     = 1'b1;
          next_state = S_IDLE;
        end else if (remaining == REM_ONE) next_state = S_IDLE;
        else                            next_state = hdma ? S_ARMED : S_RD_ADDR;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Bus strobes and address mux driven from the current byte state
  always_comb begin
    dma_rd = 1'b0;
    dma_wr = 1'b0;
    dma_a  = 16'h0000;
    case (state)
      S_RD_ADDR, S_RD_WAIT: begin
        dma_a  = src_cnt;
        dma_rd = 1'b1;
      end
      S_WR: begin
        dma_a  = dest_addr;
        dma_wr = 1'b1;
      end
      S_WR_WAIT: dma_a = dest_addr;
      default: ;
    endcase
  end

  // Register file, working counters and deferred HDMA control
  always_ff @(posedge clk) begin
    if (rst) begin
      src_reg      <= '0;
      dst_reg      <= '0;
      src_cnt      <= '0;
      dst_off      <= '0;
      byte_cnt     <= '0;
      remaining    <= '0;
      hdma         <= 1'b0;
      cancelled    <= 1'b0;
      pend_restart <= 1'b0;
      pend_cancel  <= 1'b0;
      pend_len     <= '0;
      dma_dout     <= '0;
    end else begin
      if (mmio_wr) begin
        case (mmio_sel)
          3'd0: src_reg[15:8] <= mmio_din;
          3'd1: src_reg[7:0]  <= mmio_din;
          3'd2: dst_reg[15:8] <= mmio_din;
          3'd3: dst_reg[7:0]  <= mmio_din;
          default: ;
        endcase
      end
      if (state == S_RD_WAIT) dma_dout <= dma_din;
      if (load) begin
        remaining    <= {1'b0, ld_len} + REM_ONE;
        hdma         <= ld_hdma;
        src_cnt      <= src_reg & 16'hFFF0;
        dst_off      <= DEST_BITS'(dst_reg & DST_MASK);
        byte_cnt     <= '0;
        cancelled    <= 1'b0;
        pend_restart <= 1'b0;
        pend_cancel  <= 1'b0;
      end else begin
        if (wr_hdma_ctrl) begin
          pend_restart <= mmio_din[7];
          pend_cancel  <= ~mmio_din[7];
          pend_len     <= mmio_din[LEN_BITS-1:0];
        end
        if (state == S_WR_WAIT) begin
          src_cnt  <= src_cnt + 16'd1;
          dst_off  <= dst_off + DST_ONE;
          byte_cnt <= byte_cnt + OFF_ONE;
          if (last_byte) begin
            remaining    <= rem_m1;
            pend_restart <= 1'b0;
            pend_cancel  <= 1'b0;
          end
        end
        if (cancel) cancelled <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vram_dma.sv
// tb/tb_vram_dma.sv - self-checking bench for vram_dma against a byte-level transfer model
module tb_vram_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mmio_sel;
  logic        mmio_wr;
  logic [7:0]  mmio_din;
  logic [7:0]  mmio_dout;
  logic        hblank_start;
  logic        dma_rd, dma_wr;
  logic [15:0] dma_a;
  logic [7:0]  dma_din, dma_dout;
  logic        cpu_stall, dma_occupy_extbus, dma_occupy_vidbus;

  vram_dma dut (
    .clk(clk), .rst(rst), .mmio_sel(mmio_sel), .mmio_wr(mmio_wr), .mmio_din(mmio_din),
    .mmio_dout(mmio_dout), .hblank_start(hblank_start), .dma_rd(dma_rd), .dma_wr(dma_wr),
    .dma_a(dma_a), .dma_din(dma_din), .dma_dout(dma_dout), .cpu_stall(cpu_stall),
    .dma_occupy_extbus(dma_occupy_extbus), .dma_occupy_vidbus(dma_occupy_vidbus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  assign dma_din = mem[dma_a];

  int checks = 0;
  int failures = 0;
  int stall_cnt = 0, ext_cnt = 0, vid_cnt = 0;
  logic [15:0] got_a [$];
  logic [7:0]  got_d [$];
  logic [15:0] exp_a [$];
  logic [7:0]  exp_d [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (dma_wr) begin
        got_a.push_back(dma_a);
        got_d.push_back(dma_dout);
      end
      if (cpu_stall)         stall_cnt++;
      if (dma_occupy_extbus) ext_cnt++;
      if (dma_occupy_vidbus) vid_cnt++;
    end
  end

  // Expected write stream: block-aligned source and destination, each byte read then written.
  task automatic build_exp(input logic [15:0] src, input logic [15:0] dst, input int nbytes,
                           output int ext_cycles);
    logic [15:0] s;
    int o;
    exp_a.delete();
    exp_d.delete();
    ext_cycles = 0;
    for (int i = 0; i < nbytes; i++) begin
      s = {src[15:4], 4'h0} + 16'(i);
      o = ({19'd0, dst[12:4], 4'h0} + i) % 8192;
      exp_a.push_back(16'h8000 | 16'(o));
      exp_d.push_back(mem[s]);
      if (!(s >= 16'h8000 && s < 16'hA000)) ext_cycles += 4;
    end
  endtask

  function automatic int bad_writes(input int base);
    int n = 0;
    for (int i = 0; i < exp_a.size(); i++) begin
      if (base + i >= got_a.size()) n++;
      else if (got_a[base+i] !== exp_a[i] || got_d[base+i] !== exp_d[i]) n++;
    end
    return n;
  endfunction

  task automatic wr_reg(input logic [2:0] sel, input logic [7:0] d);
    @(negedge clk);
    mmio_sel = sel; mmio_din = d; mmio_wr = 1'b1;
    @(negedge clk);
    mmio_wr = 1'b0; mmio_sel = 3'd4;
  endtask

  task automatic set_addrs(input logic [15:0] src, input logic [15:0] dst);
    wr_reg(3'd0, src[15:8]); wr_reg(3'd1, src[7:0]);
    wr_reg(3'd2, dst[15:8]); wr_reg(3'd3, dst[7:0]);
  endtask

  task automatic rd_ctrl(output logic [7:0] v);
    mmio_sel = 3'd4;
    #1 v = mmio_dout;
  endtask

  task automatic pulse;
    @(negedge clk); hblank_start = 1'b1;
    @(negedge clk); hblank_start = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rd_ctrl(v);
    checks++; if (v !== 8'hFF) begin failures++; $display("FAIL reset_ctrl got=%h exp=ff", v); end
    mmio_sel = 3'd0; #1;
    checks++; if (mmio_dout !== 8'hFF) begin failures++; $display("FAIL reset_sel0 got=%h exp=ff", mmio_dout); end
    checks++;
    if ({dma_rd, dma_wr, cpu_stall, dma_occupy_extbus, dma_occupy_vidbus} !== 5'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=00000",
        {dma_rd, dma_wr, cpu_stall, dma_occupy_extbus, dma_occupy_vidbus});
    end
    checks++; if (dma_a !== 16'h0 || dma_dout !== 8'h0) begin
      failures++; $display("FAIL reset_bus got a=%h d=%h exp 0000/00", dma_a, dma_dout); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_gdma_basic;
    int base, s0, e0, v0, ext;
    logic [7:0] v;
    base = got_a.size(); s0 = stall_cnt; e0 = ext_cnt; v0 = vid_cnt;
    set_addrs(16'hC000, 16'h0000);
    build_exp(16'hC000, 16'h0000, 32, ext);
    wr_reg(3'd4, 8'h01);
    rd_ctrl(v);
    checks++; if (v !== 8'h01) begin failures++; $display("FAIL gdma_ctrl_active got=%h exp=01", v); end
    wr_reg(3'd4, 8'h05);
    repeat (140) @(negedge clk);
    checks++; if (got_a.size() - base !== 32) begin failures++; $display("FAIL gdma_count got=%0d exp=32", got_a.size() - base); end
    checks++; if (bad_writes(base) !== 0) begin failures++; $display("FAIL gdma_data bad=%0d exp=0", bad_writes(base)); end
    checks++; if (stall_cnt - s0 !== 128) begin failures++; $display("FAIL gdma_stall got=%0d exp=128", stall_cnt - s0); end
    checks++; if (ext_cnt - e0 !== ext || vid_cnt - v0 !== 128) begin
      failures++; $display("FAIL gdma_occupy ext=%0d vid=%0d exp %0d/128", ext_cnt - e0, vid_cnt - v0, ext); end
    rd_ctrl(v);
    checks++; if (v !== 8'hFF) begin failures++; $display("FAIL gdma_ctrl_done got=%h exp=ff", v); end
  endtask

  task automatic test_gdma_random;
    int base, s0, e0, nblk, ext;
    logic [15:0] src, dst;
    for (int it = 0; it < 4; it++) begin
      src = 16'($urandom); dst = 16'($urandom); nblk = $urandom_range(1, 3);
      base = got_a.size(); s0 = stall_cnt; e0 = ext_cnt;
      set_addrs(src, dst);
      build_exp(src, dst, nblk * 16, ext);
      wr_reg(3'd4, 8'(nblk - 1));
      repeat (nblk * 64 + 6) @(negedge clk);
      checks++;
      if (bad_writes(base) !== 0 || got_a.size() - base !== nblk * 16) begin
        failures++; $display("FAIL gdma_rand%0d src=%h dst=%h bad=%0d n=%0d exp=%0d", it, src, dst,
          bad_writes(base), got_a.size() - base, nblk * 16); end
      checks++;
      if (stall_cnt - s0 !== nblk * 64 || ext_cnt - e0 !== ext) begin
        failures++; $display("FAIL gdma_rand%0d_cycles stall=%0d ext=%0d exp %0d/%0d", it,
          stall_cnt - s0, ext_cnt - e0, nblk * 64, ext); end
    end
  endtask

  task automatic test_hdma;
    int base, s0, ext;
    logic [7:0] v;
    logic [7:0] exp_rb [3];
    logic [15:0] src, dst;
    exp_rb[0] = 8'h01; exp_rb[1] = 8'h00; exp_rb[2] = 8'hFF;
    src = 16'($urandom_range(0, 16'h7FFF)); dst = 16'($urandom);
    base = got_a.size();
    set_addrs(src, dst);
    build_exp(src, dst, 48, ext);
    @(negedge clk);
    mmio_sel = 3'd4; mmio_din = 8'h82; mmio_wr = 1'b1; hblank_start = 1'b1;
    @(negedge clk);
    mmio_wr = 1'b0; hblank_start = 1'b0;
    s0 = stall_cnt;
    repeat (4) @(negedge clk);
    checks++; if (stall_cnt - s0 !== 0) begin failures++; $display("FAIL hdma_coincident stall=%0d exp=0", stall_cnt - s0); end
    rd_ctrl(v);
    checks++; if (v !== 8'h02) begin failures++; $display("FAIL hdma_armed got=%h exp=02", v); end
    for (int b = 0; b < 3; b++) begin
      s0 = stall_cnt;
      pulse();
      repeat (10) @(negedge clk);
      pulse();
      repeat (60) @(negedge clk);
      checks++; if (stall_cnt - s0 !== 64) begin failures++; $display("FAIL hdma_blk%0d_stall got=%0d exp=64", b, stall_cnt - s0); end
      rd_ctrl(v);
      checks++; if (v !== exp_rb[b]) begin failures++; $display("FAIL hdma_blk%0d_ctrl got=%h exp=%h", b, v, exp_rb[b]); end
    end
    checks++; if (bad_writes(base) !== 0 || got_a.size() - base !== 48) begin
      failures++; $display("FAIL hdma_data bad=%0d n=%0d exp=48", bad_writes(base), got_a.size() - base); end
  endtask

  task automatic test_hdma_cancel;
    int base;
    logic [7:0] v;
    base = got_a.size();
    set_addrs(16'h1230, 16'h0100);
    wr_reg(3'd4, 8'h83);
    pulse();
    repeat (70) @(negedge clk);
    wr_reg(3'd4, 8'h00);
    rd_ctrl(v);
    checks++; if (v !== 8'h82) begin failures++; $display("FAIL cancel_armed got=%h exp=82", v); end
    pulse();
    repeat (70) @(negedge clk);
    checks++; if (got_a.size() - base !== 16) begin failures++; $display("FAIL cancel_writes got=%0d exp=16", got_a.size() - base); end
    base = got_a.size();
    wr_reg(3'd4, 8'h83);
    pulse();
    repeat (20) @(negedge clk);
    wr_reg(3'd4, 8'h00);
    repeat (60) @(negedge clk);
    rd_ctrl(v);
    checks++; if (v !== 8'h82 || got_a.size() - base !== 16) begin
      failures++; $display("FAIL cancel_midblock ctrl=%h n=%0d exp 82/16", v, got_a.size() - base); end
  endtask

  task automatic test_wrap;
    int base, ext;
    base = got_a.size();
    set_addrs(16'hFFF0, 16'h1FF0);
    build_exp(16'hFFF0, 16'h1FF0, 32, ext);
    wr_reg(3'd4, 8'h01);
    repeat (140) @(negedge clk);
    checks++; if (bad_writes(base) !== 0) begin failures++; $display("FAIL wrap_data bad=%0d exp=0", bad_writes(base)); end
    checks++;
    if (got_a.size() < base + 17 || got_a[base+16] !== 16'h8000 || got_d[base+16] !== mem[0]) begin
      failures++; $display("FAIL wrap_block2 n=%0d exp addr 8000 data %h", got_a.size() - base, mem[0]); end
  endtask

  task automatic test_reset_mid;
    int base, s0, ext;
    logic [7:0] v;
    base = got_a.size();
    set_addrs(16'h4000, 16'h0200);
    wr_reg(3'd4, 8'h03);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (dma_rd !== 1'b0 || dma_wr !== 1'b0 || cpu_stall !== 1'b0) begin
      failures++; $display("FAIL rstmid_strobes got rd=%b wr=%b stall=%b exp 0", dma_rd, dma_wr, cpu_stall); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    rd_ctrl(v);
    checks++; if (v !== 8'hFF || got_a.size() - base !== 4) begin
      failures++; $display("FAIL rstmid_abort ctrl=%h n=%0d exp ff/4", v, got_a.size() - base); end
    base = got_a.size(); s0 = stall_cnt;
    set_addrs(16'h4000, 16'h0200);
    build_exp(16'h4000, 16'h0200, 16, ext);
    wr_reg(3'd4, 8'h00);
    repeat (70) @(negedge clk);
    checks++; if (bad_writes(base) !== 0 || stall_cnt - s0 !== 64) begin
      failures++; $display("FAIL rstmid_rerun bad=%0d stall=%0d exp 0/64", bad_writes(base), stall_cnt - s0); end
  endtask

  task automatic test_extbus;
    int e0, s0;
    e0 = ext_cnt; s0 = stall_cnt;
    set_addrs(16'h8000, 16'h0000);
    wr_reg(3'd4, 8'h00);
    repeat (70) @(negedge clk);
    checks++; if (ext_cnt - e0 !== 0 || stall_cnt - s0 !== 64) begin
      failures++; $display("FAIL extbus_vram ext=%0d stall=%0d exp 0/64", ext_cnt - e0, stall_cnt - s0); end
    e0 = ext_cnt;
    set_addrs(16'h4000, 16'h0000);
    wr_reg(3'd4, 8'h01);
    repeat (134) @(negedge clk);
    checks++; if (ext_cnt - e0 !== 128) begin failures++; $display("FAIL extbus_rom ext=%0d exp=128", ext_cnt - e0); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mmio_sel = 3'd4; mmio_wr = 1'b0; mmio_din = 8'h00; hblank_start = 1'b0;
    test_reset();
    test_gdma_basic();
    test_gdma_random();
    test_hdma();
    test_hdma_cancel();
    test_wrap();
    test_reset_mid();
    test_extbus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
